spi_master_core: RTL and testbench
==================================

# spi_master_core

Parametrised SPI master core for the AXI-to-SPI bridge. It is the next generation of the single-word, single-slave engine. It adds:
- generic data width;
- NUM_CS chip selects;
- multi-word bursts with per-word MOSI handshake and MISO valid strobe.

It sits between the AXI register front end, which drives the `*_in` control signals, and the SPI pins.

## Interface
- DATA_W, 32: maximum word length in bits; must be a multiple of 4.
- NUM_CS, 4: number of active-low chip selects.
- DLY_W, 8: width of the IFG / CS-to-SCK / SCK-to-CS delay fields.
- BURST_W, 4: width of the burst length field.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- start_in  in  1  transfer request; sampled in IDLE only.
- cs_sel_in  in  $clog2(NUM_CS)  slave select index.
- spi_mode_in  in  2  bit 1 = CPOL, bit 0 = CPHA.
- sck_speed_in  in  2  SCK half-period H = 2^(sck_speed_in+1) CLK cycles (2, 4, 8, 16).
- word_len_in  in  2  word length L = (word_len_in+1)*DATA_W/4 bits.
- burst_len_in  in  BURST_W  words per transfer = burst_len_in+1.
- IFG_in, CS_SCK_in, SCK_CS_in  in  DLY_W each  phase lengths in CLK cycles.
- mosi_data_in  in  DATA_W  next word to send, right-aligned.
- mosi_ready_out  out  1  one-cycle pulse: word latched, host may present the next word.
- busy_out  out  1  high from transfer accept until the end of the last IFG.
- miso_data_out  out  DATA_W  last received word, right-aligned, zero-extended.
- miso_valid_out  out  1  one-cycle pulse when miso_data_out updates.
- SCK  out  1  SPI clock.
- MOSI  out  1  SPI data out.
- MISO  in  1  SPI data in.
- CS_n  out  NUM_CS  active-low chip selects.

## Operation
- States: IDLE → CS_SETUP → XFER → CS_HOLD → IFG → (CS_SETUP if words remain, else IDLE).
- Accept:
  - In IDLE with start_in=1, latch mode, speed, L, burst count, cs_sel and all delays.
  - Latched values hold for the whole burst.
  - Load the word counter and go to CS_SETUP.
- start_in while busy_out=1 is ignored; it is neither queued nor flagged.
- Word load:
  - On every entry to CS_SETUP, latch mosi_data_in[L-1:0] into the shift register.
  - Bits above L are ignored.
  - Drive MOSI = bit L-1. Transfer is MSB first.
- CS_SETUP: CS_n[sel]=0, SCK=CPOL. Lasts max(CS_SCK_in,1) cycles.
- XFER:
  - Generate L SCK pulses with half-period H.
  - CPHA=0: sample MISO on the leading edge, shift MOSI on the trailing edge.
  - CPHA=1: shift MOSI on the leading edge, sample MISO on the trailing edge.
  - SCK returns to CPOL at the end.
- CS_HOLD: CS_n[sel] stays low, SCK=CPOL. Lasts max(SCK_CS_in,1) cycles.
- IFG:
  - All CS_n high. Lasts max(IFG_in,1) cycles.
  - The IFG also follows the last word, so back-to-back starts respect it.
- Word counter:
  - Decrements on each CS_HOLD entry.
  - At 0, IFG exits to IDLE; otherwise it goes to CS_SETUP.
- cs_sel_in ≥ NUM_CS: no CS_n asserts, but the transfer still runs with full timing.
- Idle outputs:
  - SCK = latched CPOL.
  - MOSI holds its last bit.
  - CS_n all 1.

## Timing
- Reset (RST=0): state IDLE; every output is forced immediately and asynchronously:
  - SCK=0, MOSI=0, CS_n=all 1;
  - busy_out=0, mosi_ready_out=0, miso_valid_out=0, miso_data_out=0.
- Reset mid-transfer aborts with no partial miso_valid_out. Operation resumes at the first CLK edge after release.
- start_in is sampled at edge N. From cycle N+1:
  - busy_out=1, CS_n[sel]=0, MOSI is valid;
  - mosi_ready_out pulses.
- mosi_ready_out pulses in the first cycle of every CS_SETUP.
- The host must present the next word before the next CS_SETUP entry, at least 1+max(SCK_CS_in,1)+max(IFG_in,1) cycles after XFER ends.
- XFER lasts exactly 2·L·H cycles.
- miso_valid_out pulses in the first CS_HOLD cycle. miso_data_out updates in the same cycle and holds until the next word completes.
- Per-word length = max(CS_SCK,1) + 2·L·H + max(SCK_CS,1) + max(IFG,1) cycles.
- busy_out falls in the cycle after the last IFG cycle, when the state is IDLE. A new start can be accepted at that same edge.

## Test plan
- Basic loopback:
  - Stimulus: MISO tied to MOSI; mode 0, speed 0, word_len 0 (8 bits), burst 0, delays 2/2/2, data 0xA5, cs 0.
  - Required: 8 SCK pulses, period 4 CLK; miso_data_out=0x000000A5; busy high exactly 38 cycles; only CS_n[0] low.
- Mode 3 burst:
  - Stimulus: word_len 3 (32 bits), burst 2, cs 2; slave model returns 0xDEADBEEF, 0x12345678, 0xCAFEF00D; host words 0x1, 0x2, 0x3 supplied on each mosi_ready_out.
  - Required: 3 miso_valid_out pulses with those values; MOSI bit streams match the host words; CS_n[2] high during each IFG; SCK idles high.
- Start while busy:
  - Stimulus: start_in pulsed mid-XFER.
  - Required: ignored; the transfer count is unchanged.
  - Stimulus: start_in asserted in the cycle after busy_out falls.
  - Required: accepted.
- Reset mid-transfer:
  - Stimulus: RST=0 during XFER bit 5.
  - Required: in the same cycle, CS_n all 1, SCK=0, busy_out=0; no miso_valid_out.
  - Stimulus: a new transfer after release.
  - Required: correct.
- Zero delays, slow clock:
  - Stimulus: delays 0/0/0, speed 3, word_len 1 (16 bits).
  - Required: each phase lasts 1 cycle; XFER 512 cycles; busy 515 cycles.
- Mode 1 vs mode 2 and out-of-range select:
  - Required: MISO sampled on the correct edge, checked with a slave that changes data on the opposite edge.
  - Stimulus: cs_sel_in=NUM_CS (when it fits in the port width).
  - Required: no CS_n asserts.

Source files
------------

// File: rtl/spi_master_core.sv
// -----------------------------------------------------------------------------
// spi_master_core
//   Parametrised SPI master engine for the AXI-to-SPI bridge. Runs bursts of
//   1..2^BURST_W words of length DATA_W/4 .. DATA_W bits to one of NUM_CS
//   active-low slaves. Supports SPI modes 0-3 and four SCK rates. The CS
//   setup, CS hold and inter-frame gap lengths are programmable.
//
// Ports
//   CLK, RST                system clock (rising edge), async active-low reset
//   start_in                transfer request, honoured only while idle
//   cs_sel_in               slave index; out-of-range selects no CS_n line
//   spi_mode_in             {CPOL, CPHA}
//   sck_speed_in            SCK half-period = 2^(sck_speed_in+1) CLK cycles
//   word_len_in             word length = (word_len_in+1)*DATA_W/4 bits
//   burst_len_in            words per transfer minus one
//   IFG_in/CS_SCK_in/SCK_CS_in  phase lengths in CLK cycles (0 treated as 1)
//   mosi_data_in            next word to send, right-aligned
//   mosi_ready_out          pulse: word latched, next word may be presented
//   busy_out                transfer in progress (includes trailing IFG)
//   miso_data_out           last received word, right-aligned, zero-extended
//   miso_valid_out          pulse when miso_data_out updates
//   SCK, MOSI, MISO, CS_n   SPI pins
// -----------------------------------------------------------------------------
module spi_master_core #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned NUM_CS  = 4,
   parameter int unsigned DLY_W   = 8,
   parameter int unsigned BURST_W = 4,
   localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start_in,
   input  logic [CS_W-1:0]    cs_sel_in,
   input  logic [1:0]         spi_mode_in,
   input  logic [1:0]         sck_speed_in,
   input  logic [1:0]         word_len_in,
   input  logic [BURST_W-1:0] burst_len_in,
   input  logic [DLY_W-1:0]   IFG_in,
   input  logic [DLY_W-1:0]   CS_SCK_in,
   input  logic [DLY_W-1:0]   SCK_CS_in,
   input  logic [DATA_W-1:0]  mosi_data_in,
   output logic               mosi_ready_out,
   output logic               busy_out,
   output logic [DATA_W-1:0]  miso_data_out,
   output logic               miso_valid_out,
   output logic               SCK,
   output logic               MOSI,
   input  logic               MISO,
   output logic [NUM_CS-1:0]  CS_n
);

   localparam int unsigned Q    = DATA_W / 4;
   localparam int unsigned BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CS_SETUP,
      ST_XFER,
      ST_CS_HOLD,
      ST_IFG
   } state_t;

   state_t              state_q, state_d;
   logic                cpol_q, cpol_d;
   logic                cpha_q, cpha_d;
   logic [1:0]          spd_q, spd_d;
   logic [1:0]          wlen_q, wlen_d;
   logic [BURST_W:0]    words_q, words_d;
   logic [CS_W-1:0]     sel_q, sel_d;
   logic [DLY_W-1:0]    ifg_q, ifg_d;
   logic [DLY_W-1:0]    cssck_q, cssck_d;
   logic [DLY_W-1:0]    sckcs_q, sckcs_d;
   logic [DLY_W-1:0]    cnt_q, cnt_d;
   logic [3:0]          hcnt_q, hcnt_d;
   logic                half_q, half_d;
   logic [BC_W-1:0]     bitc_q, bitc_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [DATA_W-1:0]   rx_q, rx_d;
   logic                sck_q, sck_d;
   logic [NUM_CS-1:0]   csn_q, csn_d;
   logic                busy_q, busy_d;
   logic                rdy_q, rdy_d;
   logic                mvalid_q, mvalid_d;
   logic [DATA_W-1:0]   mdata_q, mdata_d;

   logic [BC_W-1:0]     len_m1;
   logic [3:0]          half_m1;

   // Phase length minus one, with zero treated as a one-cycle phase.
   function automatic logic [DLY_W-1:0] dly_m1(input logic [DLY_W-1:0] d);
      return (d == '0) ? '0 : d - 1'b1;
   endfunction

   // Left-align the active L bits so MOSI is always the shift register MSB;
   // bits above L fall off the top.
   function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] d,
                                                    input logic [1:0] wl);
      return d << ((32'd3 - 32'(wl)) * Q);
   endfunction

   function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] s);
      logic [NUM_CS-1:0] m;
      m = '1;
      for (int unsigned i = 0; i < NUM_CS; i++) begin
         if (32'(s) == i) m[i] = 1'b0;
      end
      return m;
   endfunction

   assign len_m1  = BC_W'((32'(wlen_q) + 32'd1) * Q - 32'd1);
   assign half_m1 = 4'((32'd2 << spd_q) - 32'd1);

   always_comb begin
      state_d  = state_q;
      cpol_d   = cpol_q;
      cpha_d   = cpha_q;
      spd_d    = spd_q;
      wlen_d   = wlen_q;
      words_d  = words_q;
      sel_d    = sel_q;
      ifg_d    = ifg_q;
      cssck_d  = cssck_q;
      sckcs_d  = sckcs_q;
      cnt_d    = cnt_q;
      hcnt_d   = hcnt_q;
      half_d   = half_q;
      bitc_d   = bitc_q;
      tx_d     = tx_q;
      rx_d     = rx_q;
      sck_d    = sck_q;
      mdata_d  = mdata_q;
      mvalid_d = 1'b0;
      rdy_d    = 1'b0;
      busy_d   = 1'b0;
      csn_d    = '1;

      case (state_q)
         ST_IDLE: begin
            sck_d = cpol_q;
            if (start_in) begin
               cpol_d  = spi_mode_in[1];
               cpha_d  = spi_mode_in[0];
               spd_d   = sck_speed_in;
               wlen_d  = word_len_in;
               sel_d   = cs_sel_in;
               ifg_d   = IFG_in;
               cssck_d = CS_SCK_in;
               sckcs_d = SCK_CS_in;
               words_d = (BURST_W+1)'(burst_len_in) + 1'b1;
               cnt_d   = dly_m1(CS_SCK_in);
               tx_d    = align_word(mosi_data_in, word_len_in);
               rx_d    = '0;
               sck_d   = spi_mode_in[1];
               state_d = ST_CS_SETUP;
            end
         end

         ST_CS_SETUP: begin
            if (cnt_q == '0) begin
               hcnt_d  = half_m1;
               half_d  = 1'b0;
               bitc_d  = '0;
               state_d = ST_XFER;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_XFER: begin
            if (hcnt_q != '0) begin
               hcnt_d = hcnt_q - 1'b1;
            end else begin
               hcnt_d = half_m1;
               sck_d  = ~sck_q;
               if (!half_q) begin
                  // Leading edge. With CPHA=1 the first bit is already on
                  // MOSI from the word load, so only later bits shift here.
                  half_d = 1'b1;
                  if (!cpha_q) begin
                     rx_d = {rx_q[DATA_W-2:0], MISO};
                  end else if (bitc_q != '0) begin
                     tx_d = tx_q << 1;
                  end
               end else begin
                  // Trailing edge. The final one returns SCK to CPOL and
                  // ends the word; MOSI is left holding the last bit.
                  half_d = 1'b0;
                  if (cpha_q) rx_d = {rx_q[DATA_W-2:0], MISO};
                  if (bitc_q == len_m1) begin
                     cnt_d   = dly_m1(sckcs_q);
                     state_d = ST_CS_HOLD;
                  end else begin
                     bitc_d = bitc_q + 1'b1;
                     if (!cpha_q) tx_d = tx_q << 1;
                  end
               end
            end
         end

         ST_CS_HOLD: begin
            if (cnt_q == '0) begin
               cnt_d   = dly_m1(ifg_q);
               state_d = ST_IFG;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_IFG: begin
            if (cnt_q == '0) begin
               if (words_q == '0) begin
                  state_d = ST_IDLE;
               end else begin
                  cnt_d   = dly_m1(cssck_q);
                  tx_d    = align_word(mosi_data_in, wlen_q);
                  rx_d    = '0;
                  state_d = ST_CS_SETUP;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      // Registered outputs are decoded from the next state so they line up
      // with the state they describe.
      rdy_d  = (state_d == ST_CS_SETUP) && (state_q != ST_CS_SETUP);
      busy_d = (state_d != ST_IDLE);
      if ((state_d == ST_CS_HOLD) && (state_q == ST_XFER)) begin
         mvalid_d = 1'b1;
         mdata_d  = rx_d;
         words_d  = words_q - 1'b1;
      end
      if ((state_d == ST_CS_SETUP) || (state_d == ST_XFER) || (state_d == ST_CS_HOLD)) begin
         csn_d = cs_decode(sel_d);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q  <= ST_IDLE;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         spd_q    <= '0;
         wlen_q   <= '0;
         words_q  <= '0;
         sel_q    <= '0;
         ifg_q    <= '0;
         cssck_q  <= '0;
         sckcs_q  <= '0;
         cnt_q    <= '0;
         hcnt_q   <= '0;
         half_q   <= 1'b0;
         bitc_q   <= '0;
         tx_q     <= '0;
         rx_q     <= '0;
         sck_q    <= 1'b0;
         csn_q    <= '1;
         busy_q   <= 1'b0;
         rdy_q    <= 1'b0;
         mvalid_q <= 1'b0;
         mdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cpol_q   <= cpol_d;
         cpha_q   <= cpha_d;
         spd_q    <= spd_d;
         wlen_q   <= wlen_d;
         words_q  <= words_d;
         sel_q    <= sel_d;
         ifg_q    <= ifg_d;
         cssck_q  <= cssck_d;
         sckcs_q  <= sckcs_d;
         cnt_q    <= cnt_d;
         hcnt_q   <= hcnt_d;
         half_q   <= half_d;
         bitc_q   <= bitc_d;
         tx_q     <= tx_d;
         rx_q     <= rx_d;
         sck_q    <= sck_d;
         csn_q    <= csn_d;
         busy_q   <= busy_d;
         rdy_q    <= rdy_d;
         mvalid_q <= mvalid_d;
         mdata_q  <= mdata_d;
      end
   end

   assign SCK            = sck_q;
   assign MOSI           = tx_q[DATA_W-1];
   assign CS_n           = csn_q;
   assign busy_out       = busy_q;
   assign mosi_ready_out = rdy_q;
   assign miso_valid_out = mvalid_q;
   assign miso_data_out  = mdata_q;

endmodule

// File: tb/tb_spi_master_core.sv
// -----------------------------------------------------------------------------
// tb_spi_master_core
//   Scenario-driven bench for spi_master_core. A negedge monitor acts as the
//   SPI slave (or MISO is looped back to MOSI), records received words and
//   pin timing; expected words are queued as stimulus is issued and compared
//   against the observed queues by each scenario task.
// -----------------------------------------------------------------------------
module tb_spi_master_core;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned NUM_CS  = 4;
   localparam int unsigned DLY_W   = 8;
   localparam int unsigned BURST_W = 4;

   logic              CLK = 1'b0;
   logic              RST;
   logic              start_in;
   logic [1:0]        cs_sel_in;
   logic [1:0]        spi_mode_in;
   logic [1:0]        sck_speed_in;
   logic [1:0]        word_len_in;
   logic [3:0]        burst_len_in;
   logic [7:0]        IFG_in, CS_SCK_in, SCK_CS_in;
   logic [31:0]       mosi_data_in;
   logic              mosi_ready_out, busy_out, miso_valid_out;
   logic [31:0]       miso_data_out;
   logic              SCK, MOSI, MISO;
   logic [3:0]        CS_n;

   bit                loopback;
   logic              slv_miso;

   int checks = 0;
   int errors = 0;

   // slave / monitor configuration and state
   bit          tb_cpol, tb_cpha;
   int          tb_len;
   int          cyc, busy_cnt, rdy_cnt, sck_toggles, lead_period, last_lead;
   int          cs_rise, sck_idle_bad, cs_fall_cyc, valid_cyc;
   logic [3:0]  cs_seen;
   bit          prev_sck, prev_cs_act, cs_act, lead;
   logic [31:0] slv_word, mosi_word;
   int          slv_bit, rx_cnt;

   logic [31:0] slv_q[$];
   logic [31:0] exp_miso_q[$], obs_miso_q[$];
   logic [31:0] exp_mosi_q[$], obs_mosi_q[$];

   always #5 CLK = ~CLK;

   assign MISO = loopback ? MOSI : slv_miso;

   spi_master_core #(
      .DATA_W (DATA_W),
      .NUM_CS (NUM_CS),
      .DLY_W  (DLY_W),
      .BURST_W(BURST_W)
   ) dut (
      .CLK           (CLK),
      .RST           (RST),
      .start_in      (start_in),
      .cs_sel_in     (cs_sel_in),
      .spi_mode_in   (spi_mode_in),
      .sck_speed_in  (sck_speed_in),
      .word_len_in   (word_len_in),
      .burst_len_in  (burst_len_in),
      .IFG_in        (IFG_in),
      .CS_SCK_in     (CS_SCK_in),
      .SCK_CS_in     (SCK_CS_in),
      .mosi_data_in  (mosi_data_in),
      .mosi_ready_out(mosi_ready_out),
      .busy_out      (busy_out),
      .miso_data_out (miso_data_out),
      .miso_valid_out(miso_valid_out),
      .SCK           (SCK),
      .MOSI          (MOSI),
      .MISO          (MISO),
      .CS_n          (CS_n)
   );

   // Monitor and slave model, evaluated on the inactive clock edge.
   always @(negedge CLK) begin
      cyc++;
      cs_act = (CS_n != 4'hF);
      if (miso_valid_out) begin
         obs_miso_q.push_back(miso_data_out);
         valid_cyc = cyc;
      end
      if (busy_out) busy_cnt++;
      if (mosi_ready_out) rdy_cnt++;
      cs_seen = cs_seen | ~CS_n;
      if (!cs_act && prev_cs_act) cs_rise++;
      if (busy_out && !cs_act && (SCK !== tb_cpol)) sck_idle_bad++;
      if (cs_act && !prev_cs_act) begin
         cs_fall_cyc = cyc;
         slv_word  = (slv_q.size() > 0) ? slv_q.pop_front() : 32'h0;
         slv_bit   = tb_len;
         rx_cnt    = 0;
         mosi_word = 32'h0;
         slv_miso  = 1'b0;
         if (!tb_cpha) begin
            slv_bit--;
            slv_miso = slv_word[slv_bit];
         end
      end else if (cs_act && prev_cs_act && (SCK !== prev_sck)) begin
         sck_toggles++;
         lead = (SCK !== tb_cpol);
         if (lead) begin
            if (last_lead > 0) lead_period = cyc - last_lead;
            last_lead = cyc;
         end
         if (lead != tb_cpha) begin
            mosi_word = {mosi_word[30:0], MOSI};
            rx_cnt++;
            if (rx_cnt == tb_len) obs_mosi_q.push_back(mosi_word);
         end else if (slv_bit > 0) begin
            slv_bit--;
            slv_miso = slv_word[slv_bit];
         end
      end
      prev_sck    = SCK;
      prev_cs_act = cs_act;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge CLK);
         #1;
      end
   endtask

   task automatic clear_mon();
      busy_cnt = 0; rdy_cnt = 0; sck_toggles = 0; lead_period = 0; last_lead = 0;
      cs_rise = 0; sck_idle_bad = 0; cs_fall_cyc = 0; valid_cyc = 0; cs_seen = 4'h0;
      exp_miso_q.delete(); obs_miso_q.delete();
      exp_mosi_q.delete(); obs_mosi_q.delete();
   endtask

   // Drives one start request; returns in the cycle after acceptance.
   task automatic do_start(input logic [1:0] mode, input logic [1:0] spd,
                           input logic [1:0] wl, input logic [3:0] burst,
                           input logic [1:0] cs, input logic [7:0] ifg,
                           input logic [7:0] cssck, input logic [7:0] sckcs,
                           input logic [31:0] data);
      tb_cpol = mode[1];
      tb_cpha = mode[0];
      tb_len  = (int'(wl) + 1) * 8;
      spi_mode_in  = mode;
      sck_speed_in = spd;
      word_len_in  = wl;
      burst_len_in = burst;
      cs_sel_in    = cs;
      IFG_in       = ifg;
      CS_SCK_in    = cssck;
      SCK_CS_in    = sckcs;
      mosi_data_in = data;
      start_in     = 1'b1;
      tick(1);
      start_in     = 1'b0;
   endtask

   task automatic wait_idle(input int max, output bit ok);
      int n;
      n = 0;
      while (busy_out && n < max) begin
         tick(1);
         n++;
      end
      ok = !busy_out;
   endtask

   task automatic test_reset();
      RST = 1'b0;
      start_in = 1'b0; cs_sel_in = '0; spi_mode_in = '0; sck_speed_in = '0;
      word_len_in = '0; burst_len_in = '0; IFG_in = '0; CS_SCK_in = '0;
      SCK_CS_in = '0; mosi_data_in = '0; loopback = 1'b0; slv_miso = 1'b0;
      tb_cpol = 1'b0; tb_cpha = 1'b0; tb_len = 8;
      tick(2);
      checks++; if (SCK !== 1'b0) begin errors++; $display("FAIL reset_sck got %b exp 0", SCK); end
      checks++; if (MOSI !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", MOSI); end
      checks++; if (CS_n !== 4'hF) begin errors++; $display("FAIL reset_csn got %h exp f", CS_n); end
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_out); end
      checks++; if (mosi_ready_out !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b exp 0", mosi_ready_out); end
      checks++; if (miso_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", miso_valid_out); end
      checks++; if (miso_data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", miso_data_out); end
      RST = 1'b1;
      tick(2);
   endtask

   task automatic test_loopback();
      bit ok;
      clear_mon();
      loopback = 1'b1;
      exp_miso_q.push_back(32'hA5);
      exp_mosi_q.push_back(32'hA5);
      do_start(2'd0, 2'd0, 2'd0, 4'd0, 2'd0, 8'd2, 8'd2, 8'd2, 32'hA5);
      checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL lb_busy_n1 got %b exp 1", busy_out); end
      checks++; if (mosi_ready_out !== 1'b1) begin errors++; $display("FAIL lb_rdy_n1 got %b exp 1", mosi_ready_out); end
      checks++; if (CS_n !== 4'b1110) begin errors++; $display("FAIL lb_csn_n1 got %b exp 1110", CS_n); end
      checks++; if (MOSI !== 1'b1) begin errors++; $display("FAIL lb_mosi_n1 got %b exp 1", MOSI); end
      wait_idle(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL lb_timeout busy=%b exp 0", busy_out); end
      tick(2);
      checks++; if (busy_cnt != 38) begin errors++; $display("FAIL lb_busy_len got %0d exp 38", busy_cnt); end
      checks++; if (sck_toggles != 16) begin errors++; $display("FAIL lb_sck_edges got %0d exp 16", sck_toggles); end
      checks++; if (lead_period != 4) begin errors++; $display("FAIL lb_sck_period got %0d exp 4", lead_period); end
      checks++; if (cs_seen !== 4'b0001) begin errors++; $display("FAIL lb_cs_seen got %b exp 0001", cs_seen); end
      checks++; if (obs_miso_q.size() != exp_miso_q.size()) begin errors++; $display("FAIL lb_miso_count got %0d exp %0d", obs_miso_q.size(), exp_miso_q.size()); end
      while (exp_miso_q.size() > 0 && obs_miso_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_miso_q.pop_front(); o = obs_miso_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL lb_miso got %h exp %h", o, e); end
      end
      while (exp_mosi_q.size() > 0 && obs_mosi_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_mosi_q.pop_front(); o = obs_mosi_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL lb_mosi got %h exp %h", o, e); end
      end
   endtask

   task automatic test_mode3_burst();
      bit ok;
      int n;
      clear_mon();
      loopback = 1'b0;
      slv_q.delete();
      slv_q.push_back(32'hDEADBEEF); slv_q.push_back(32'h12345678); slv_q.push_back(32'hCAFEF00D);
      exp_miso_q.push_back(32'hDEADBEEF); exp_miso_q.push_back(32'h12345678); exp_miso_q.push_back(32'hCAFEF00D);
      exp_mosi_q.push_back(32'h1); exp_mosi_q.push_back(32'h2); exp_mosi_q.push_back(32'h3);
      do_start(2'd3, 2'd0, 2'd3, 4'd2, 2'd2, 8'd1, 8'd1, 8'd1, 32'h1);
      checks++; if (mosi_ready_out !== 1'b1) begin errors++; $display("FAIL b_rdy0 got %b exp 1", mosi_ready_out); end
      mosi_data_in = 32'h2;
      n = 0;
      tick(1);
      while (!mosi_ready_out && n < 400) begin tick(1); n++; end
      checks++; if (mosi_ready_out !== 1'b1) begin errors++; $display("FAIL b_rdy1_timeout got %b exp 1", mosi_ready_out); end
      mosi_data_in = 32'h3;
      wait_idle(600, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b_timeout busy=%b exp 0", busy_out); end
      tick(2);
      checks++; if (rdy_cnt != 3) begin errors++; $display("FAIL b_rdy_count got %0d exp 3", rdy_cnt); end
      checks++; if (cs_seen !== 4'b0100) begin errors++; $display("FAIL b_cs_seen got %b exp 0100", cs_seen); end
      checks++; if (cs_rise != 3) begin errors++; $display("FAIL b_cs_deassert got %0d exp 3", cs_rise); end
      checks++; if (sck_idle_bad != 0) begin errors++; $display("FAIL b_sck_idle got %0d exp 0", sck_idle_bad); end
      checks++; if (SCK !== 1'b1) begin errors++; $display("FAIL b_sck_idle_high got %b exp 1", SCK); end
      checks++; if (obs_miso_q.size() != exp_miso_q.size()) begin errors++; $display("FAIL b_miso_count got %0d exp %0d", obs_miso_q.size(), exp_miso_q.size()); end
      checks++; if (obs_mosi_q.size() != exp_mosi_q.size()) begin errors++; $display("FAIL b_mosi_count got %0d exp %0d", obs_mosi_q.size(), exp_mosi_q.size()); end
      while (exp_miso_q.size() > 0 && obs_miso_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_miso_q.pop_front(); o = obs_miso_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL b_miso got %h exp %h", o, e); end
      end
      while (exp_mosi_q.size() > 0 && obs_mosi_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_mosi_q.pop_front(); o = obs_mosi_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL b_mosi got %h exp %h", o, e); end
      end
   endtask

   task automatic test_start_busy();
      bit ok;
      clear_mon();
      loopback = 1'b1;
      exp_miso_q.push_back(32'h3C);
      do_start(2'd0, 2'd1, 2'd0, 4'd0, 2'd1, 8'd1, 8'd1, 8'd1, 32'h3C);
      tick(20);
      cs_sel_in = 2'd3;
      mosi_data_in = 32'hFF;
      start_in = 1'b1;
      tick(1);
      start_in = 1'b0;
      wait_idle(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL sb_timeout busy=%b exp 0", busy_out); end
      checks++; if (busy_cnt != 67) begin errors++; $display("FAIL sb_busy_len got %0d exp 67", busy_cnt); end
      checks++; if (rdy_cnt != 1) begin errors++; $display("FAIL sb_xfer_count got %0d exp 1", rdy_cnt); end
      checks++; if (cs_seen !== 4'b0010) begin errors++; $display("FAIL sb_cs_seen got %b exp 0010", cs_seen); end
      checks++; if (obs_miso_q.size() != 1) begin errors++; $display("FAIL sb_miso_count got %0d exp 1", obs_miso_q.size()); end
      while (exp_miso_q.size() > 0 && obs_miso_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_miso_q.pop_front(); o = obs_miso_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL sb_miso got %h exp %h", o, e); end
      end
      // first idle cycle: a start here must be taken at the next edge
      clear_mon();
      exp_miso_q.push_back(32'h81);
      do_start(2'd0, 2'd1, 2'd0, 4'd0, 2'd1, 8'd1, 8'd1, 8'd1, 32'h81);
      checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b exp 1", busy_out); end
      checks++; if (mosi_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_rdy got %b exp 1", mosi_ready_out); end
      wait_idle(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout busy=%b exp 0", busy_out); end
      tick(2);
      while (exp_miso_q.size() > 0 && obs_miso_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_miso_q.pop_front(); o = obs_miso_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL b2b_miso got %h exp %h", o, e); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      int n;
      clear_mon();
      loopback = 1'b0;
      slv_q.delete();
      slv_q.push_back(32'h77);
      do_start(2'd2, 2'd1, 2'd0, 4'd0, 2'd0, 8'd1, 8'd1, 8'd1, 32'hC3);
      n = 0;
      while (sck_toggles < 10 && n < 200) begin tick(1); n++; end
      checks++; if (sck_toggles < 10) begin errors++; $display("FAIL rm_reach_bit5 got %0d exp 10", sck_toggles); end
      #2;
      RST = 1'b0;
      #1;
      checks++; if (CS_n !== 4'hF) begin errors++; $display("FAIL rm_csn got %h exp f", CS_n); end
      checks++; if (SCK !== 1'b0) begin errors++; $display("FAIL rm_sck got %b exp 0", SCK); end
      checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy_out); end
      tick(3);
      RST = 1'b1;
      tick(5);
      checks++; if (obs_miso_q.size() != 0) begin errors++; $display("FAIL rm_no_valid got %0d exp 0", obs_miso_q.size()); end
      slv_q.delete();
      clear_mon();
      loopback = 1'b1;
      exp_miso_q.push_back(32'h5E);
      do_start(2'd0, 2'd0, 2'd0, 4'd0, 2'd3, 8'd1, 8'd1, 8'd1, 32'h5E);
      wait_idle(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rm_post_timeout busy=%b exp 0", busy_out); end
      tick(2);
      checks++; if (cs_seen !== 4'b1000) begin errors++; $display("FAIL rm_post_cs got %b exp 1000", cs_seen); end
      checks++; if (obs_miso_q.size() != 1) begin errors++; $display("FAIL rm_post_count got %0d exp 1", obs_miso_q.size()); end
      while (exp_miso_q.size() > 0 && obs_miso_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_miso_q.pop_front(); o = obs_miso_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL rm_post_miso got %h exp %h", o, e); end
      end
   endtask

   task automatic test_zero_delay();
      bit ok;
      clear_mon();
      loopback = 1'b1;
      exp_miso_q.push_back(32'hBEEF);
      do_start(2'd0, 2'd3, 2'd1, 4'd0, 2'd0, 8'd0, 8'd0, 8'd0, 32'hBEEF);
      wait_idle(1000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL zd_timeout busy=%b exp 0", busy_out); end
      tick(2);
      checks++; if (busy_cnt != 515) begin errors++; $display("FAIL zd_busy_len got %0d exp 515", busy_cnt); end
      checks++; if (valid_cyc - cs_fall_cyc != 513) begin errors++; $display("FAIL zd_setup_xfer got %0d exp 513", valid_cyc - cs_fall_cyc); end
      checks++; if (lead_period != 32) begin errors++; $display("FAIL zd_sck_period got %0d exp 32", lead_period); end
      while (exp_miso_q.size() > 0 && obs_miso_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_miso_q.pop_front(); o = obs_miso_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL zd_miso got %h exp %h", o, e); end
      end
   endtask

   task automatic test_mode12();
      bit ok;
      // mode 1
      clear_mon();
      loopback = 1'b0;
      slv_q.delete();
      slv_q.push_back(32'h96);
      exp_miso_q.push_back(32'h96);
      exp_mosi_q.push_back(32'h4B);
      do_start(2'd1, 2'd0, 2'd0, 4'd0, 2'd0, 8'd1, 8'd1, 8'd1, 32'h4B);
      wait_idle(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL m1_timeout busy=%b exp 0", busy_out); end
      tick(2);
      checks++; if (obs_miso_q.size() != 1) begin errors++; $display("FAIL m1_count got %0d exp 1", obs_miso_q.size()); end
      while (exp_miso_q.size() > 0 && obs_miso_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_miso_q.pop_front(); o = obs_miso_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL m1_miso got %h exp %h", o, e); end
      end
      while (exp_mosi_q.size() > 0 && obs_mosi_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_mosi_q.pop_front(); o = obs_mosi_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL m1_mosi got %h exp %h", o, e); end
      end
      // mode 2, upper host bits beyond the word length must be ignored
      clear_mon();
      slv_q.push_back(32'h5A);
      exp_miso_q.push_back(32'h5A);
      exp_mosi_q.push_back(32'hE1);
      do_start(2'd2, 2'd1, 2'd0, 4'd0, 2'd1, 8'd1, 8'd3, 8'd1, 32'hFFFF_FFE1);
      wait_idle(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL m2_timeout busy=%b exp 0", busy_out); end
      tick(2);
      checks++; if (SCK !== 1'b1) begin errors++; $display("FAIL m2_sck_idle got %b exp 1", SCK); end
      checks++; if (cs_seen !== 4'b0010) begin errors++; $display("FAIL m2_cs_seen got %b exp 0010", cs_seen); end
      checks++; if (obs_mosi_q.size() != 1) begin errors++; $display("FAIL m2_mosi_count got %0d exp 1", obs_mosi_q.size()); end
      while (exp_miso_q.size() > 0 && obs_miso_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_miso_q.pop_front(); o = obs_miso_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL m2_miso got %h exp %h", o, e); end
      end
      while (exp_mosi_q.size() > 0 && obs_mosi_q.size() > 0) begin
         logic [31:0] e, o;
         e = exp_mosi_q.pop_front(); o = obs_mosi_q.pop_front();
         checks++; if (o !== e) begin errors++; $display("FAIL m2_mosi got %h exp %h", o, e); end
      end
   endtask

   initial begin
      cyc = 0;
      test_reset();
      test_loopback();
      test_mode3_burst();
      test_start_busy();
      test_reset_mid();
      test_zero_delay();
      test_mode12();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
